// File: rtl/ber_sync_checker.sv
// -----------------------------------------------------------------------------
// ber_sync_checker
//
// Per-channel BER checker for the I/Q PRBS9 links. The module finds the link
// delay on its own. It runs a serial search over a reference delay line, then
// locks, and then watches for loss of lock. It keeps saturating bit, error and
// loss-of-lock counters.
//
// Optional build macro: BER_PHASE_AMBIG_EN
//   When defined, the search also tests the inverted comparison at each
//   candidate delay. This resolves the QPSK 180-degree ambiguity. The macro
//   also adds the o_inverted output.
//
// Ports
//   clock        in   T/4 system clock
//   i_reset      in   asynchronous reset, active low
//   i_enb_rx     in   receiver enable
//   i_valid      in   sample strobe, one cycle per symbol
//   i_ref        in   local PRBS reference bit
//   i_rx         in   received hard decision
//   i_clr        in   synchronous clear of bit/error/LOL counters
//   o_state      out  00 IDLE, 01 SEARCH, 10 LOCK
//   o_locked     out  high while in LOCK
//   o_delay      out  current (searching) or locked candidate delay
//   o_count_bit  out  bits compared while locked (saturating)
//   o_count_err  out  errors while locked (saturating)
//   o_lol_cnt    out  loss-of-lock events (saturating)
//   o_led        out  locked and zero errors in the last completed LOL window
//   o_inverted   out  accepted polarity (only with BER_PHASE_AMBIG_EN)
// -----------------------------------------------------------------------------
module ber_sync_checker #(
  parameter int NB_DLY     = 10,
  parameter int NB_CNT     = 64,
  parameter int SEARCH_LEN = 511,
  parameter int ACQ_THR    = 0,
  parameter int LOL_WIN    = 512,
  parameter int LOL_THR    = 64,
  parameter int NB_LOL     = 8
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enb_rx,
  input  logic              i_valid,
  input  logic              i_ref,
  input  logic              i_rx,
  input  logic              i_clr,
  output logic [1:0]        o_state,
  output logic              o_locked,
  output logic [NB_DLY-1:0] o_delay,
  output logic [NB_CNT-1:0] o_count_bit,
  output logic [NB_CNT-1:0] o_count_err,
  output logic [NB_LOL-1:0] o_lol_cnt,
  output logic              o_led
`ifdef BER_PHASE_AMBIG_EN
  ,
  output logic              o_inverted
`endif
);

  localparam int DEPTH = 2 ** NB_DLY;
  localparam int NB_SS = $clog2(SEARCH_LEN + 1);  // search sample counter
  localparam int NB_SE = $clog2(ACQ_THR + 2);     // search error counter
  localparam int NB_LS = $clog2(LOL_WIN + 1);     // LOL sample counter
  localparam int NB_LE = $clog2(LOL_THR + 2);     // LOL error counter

  localparam logic [NB_SS-1:0] SS_LAST = NB_SS'(SEARCH_LEN - 1);
  localparam logic [NB_SE-1:0] SE_THR  = NB_SE'(ACQ_THR);
  // The error counters only need to tell "at or below threshold" from
  // "above threshold", so they stop one step past the threshold.
  localparam logic [NB_SE-1:0] SE_MAX  = NB_SE'(ACQ_THR + 1);
  localparam logic [NB_LS-1:0] LS_LAST = NB_LS'(LOL_WIN - 1);
  localparam logic [NB_LE-1:0] LE_THR  = NB_LE'(LOL_THR);
  localparam logic [NB_LE-1:0] LE_MAX  = NB_LE'(LOL_THR + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_LOCK   = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [NB_DLY-1:0] d_q, d_d;
  logic [NB_SS-1:0]  s_cnt_q, s_cnt_d;
  logic [NB_SE-1:0]  s_err_q, s_err_d, s_err_inc;
  logic [NB_LS-1:0]  l_cnt_q, l_cnt_d;
  logic [NB_LE-1:0]  l_err_q, l_err_d, l_err_inc;
  logic              led_flag_q, led_flag_d;
  logic [NB_CNT-1:0] cnt_bit_q, cnt_bit_d;
  logic [NB_CNT-1:0] cnt_err_q, cnt_err_d;
  logic [NB_LOL-1:0] lol_cnt_q, lol_cnt_d;
  logic              locked_q;
  logic              led_q;
  logic [DEPTH-1:0]  dl_q;

  logic smp;
  logic ref_sel;
  logic err_raw;
  logic err_lock;
  logic pol;
  logic acc_n;
  logic acc_any;
  logic win_clr;

`ifdef BER_PHASE_AMBIG_EN
  logic [NB_SE-1:0] s_erri_q, s_erri_d, s_erri_inc;
  logic             inv_q, inv_d;
  logic             acc_i;

  assign pol = inv_q;
`else
  assign pol = 1'b0;
`endif

  // All sample processing is qualified by the strobe and the enable.
  assign smp = i_valid & i_enb_rx;

  // dl_q[0] holds the sample one strobe ago. Delay 0 uses the live input.
  assign ref_sel  = (d_q == '0) ? i_ref : dl_q[d_q - NB_DLY'(1)];
  assign err_raw  = i_rx ^ ref_sel;
  assign err_lock = err_raw ^ pol;

  // ---------------------------------------------------------------------------
  // Reference delay line
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      dl_q <= '0;
    end else if (smp) begin
      dl_q <= {dl_q[DEPTH-2:0], i_ref};
    end
  end

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      d_q        <= '0;
      s_cnt_q    <= '0;
      s_err_q    <= '0;
      l_cnt_q    <= '0;
      l_err_q    <= '0;
      led_flag_q <= 1'b0;
      cnt_bit_q  <= '0;
      cnt_err_q  <= '0;
      lol_cnt_q  <= '0;
      locked_q   <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      s_cnt_q    <= s_cnt_d;
      s_err_q    <= s_err_d;
      l_cnt_q    <= l_cnt_d;
      l_err_q    <= l_err_d;
      led_flag_q <= led_flag_d;
      cnt_bit_q  <= cnt_bit_d;
      cnt_err_q  <= cnt_err_d;
      lol_cnt_q  <= lol_cnt_d;
      // These are derived from the next state, so they align with o_state.
      locked_q   <= (state_d == ST_LOCK);
      led_q      <= (state_d == ST_LOCK) & led_flag_d;
    end
  end

`ifdef BER_PHASE_AMBIG_EN
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      s_erri_q <= '0;
      inv_q    <= 1'b0;
    end else begin
      s_erri_q <= s_erri_d;
      inv_q    <= inv_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    s_cnt_d    = s_cnt_q;
    s_err_d    = s_err_q;
    l_cnt_d    = l_cnt_q;
    l_err_d    = l_err_q;
    led_flag_d = led_flag_q;
    cnt_bit_d  = cnt_bit_q;
    cnt_err_d  = cnt_err_q;
    lol_cnt_d  = lol_cnt_q;
    win_clr    = 1'b0;

    // Window error counts including the current sample, so that the final
    // sample of a window takes part in its own decision.
    s_err_inc = s_err_q;
    if (err_raw && (s_err_q != SE_MAX)) s_err_inc = s_err_q + NB_SE'(1);
    l_err_inc = l_err_q;
    if (err_lock && (l_err_q != LE_MAX)) l_err_inc = l_err_q + NB_LE'(1);

    acc_n = (s_err_inc <= SE_THR);

`ifdef BER_PHASE_AMBIG_EN
    s_erri_d   = s_erri_q;
    inv_d      = inv_q;
    s_erri_inc = s_erri_q;
    if (!err_raw && (s_erri_q != SE_MAX)) s_erri_inc = s_erri_q + NB_SE'(1);
    acc_i      = (s_erri_inc <= SE_THR);
    acc_any    = acc_n | acc_i;
`else
    acc_any    = acc_n;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_enb_rx) state_d = ST_SEARCH;
      end

      ST_SEARCH: begin
        if (!i_enb_rx) begin
          state_d = ST_IDLE;
          win_clr = 1'b1;
        end else if (smp) begin
          if (s_cnt_q == SS_LAST) begin
            win_clr = 1'b1;
            if (acc_any) begin
              state_d    = ST_LOCK;
              led_flag_d = 1'b0;
`ifdef BER_PHASE_AMBIG_EN
              // The non-inverted compare wins when both polarities qualify.
              inv_d      = ~acc_n;
`endif
            end else begin
              d_d = d_q + NB_DLY'(1);  // wraps from the deepest tap back to 0
            end
          end else begin
            s_cnt_d = s_cnt_q + NB_SS'(1);
            s_err_d = s_err_inc;
`ifdef BER_PHASE_AMBIG_EN
            s_erri_d = s_erri_inc;
`endif
          end
        end
      end

      ST_LOCK: begin
        if (!i_enb_rx) begin
          state_d    = ST_IDLE;
          win_clr    = 1'b1;
          led_flag_d = 1'b0;
        end else if (smp) begin
          // A saturated bit count freezes the error count as well, so the
          // ratio stays meaningful.
          if (cnt_bit_q != '1) begin
            cnt_bit_d = cnt_bit_q + NB_CNT'(1);
            if (err_lock && (cnt_err_q != '1)) cnt_err_d = cnt_err_q + NB_CNT'(1);
          end
          if (l_cnt_q == LS_LAST) begin
            win_clr = 1'b1;
            if (l_err_inc > LE_THR) begin
              // Resume the search at the delay that was locked.
              state_d    = ST_SEARCH;
              led_flag_d = 1'b0;
              if (lol_cnt_q != '1) lol_cnt_d = lol_cnt_q + NB_LOL'(1);
            end else begin
              led_flag_d = (l_err_inc == '0);
            end
          end else begin
            l_cnt_d = l_cnt_q + NB_LS'(1);
            l_err_d = l_err_inc;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        win_clr = 1'b1;
      end
    endcase

    if (win_clr) begin
      s_cnt_d = '0;
      s_err_d = '0;
      l_cnt_d = '0;
      l_err_d = '0;
`ifdef BER_PHASE_AMBIG_EN
      s_erri_d = '0;
`endif
    end

    // A clear takes priority over any increment in the same cycle.
    if (i_clr) begin
      cnt_bit_d = '0;
      cnt_err_d = '0;
      lol_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all taken directly from registers)
  // ---------------------------------------------------------------------------
  assign o_state     = state_q;
  assign o_locked    = locked_q;
  assign o_delay     = d_q;
  assign o_count_bit = cnt_bit_q;
  assign o_count_err = cnt_err_q;
  assign o_lol_cnt   = lol_cnt_q;
  assign o_led       = led_q;
`ifdef BER_PHASE_AMBIG_EN
  assign o_inverted  = inv_q;
`endif

endmodule

// File: tb/tb_ber_sync_checker.sv
// -----------------------------------------------------------------------------
// tb_ber_sync_checker
//
// Drives a PRBS9 reference and a copy of it delayed by 37 valid samples into
// the checker. Expected output values are pushed to a scoreboard queue as the
// stimulus is issued. They are popped and compared at the check points.
// -----------------------------------------------------------------------------
module tb_ber_sync_checker;

  localparam int NB_DLY = 10;
  localparam int NB_CNT = 64;
  localparam int NB_LOL = 8;
  localparam int SL     = 511;
  localparam int LW     = 512;

  localparam int SEL_STATE = 0;
  localparam int SEL_LOCK  = 1;
  localparam int SEL_DLY   = 2;
  localparam int SEL_BIT   = 3;
  localparam int SEL_ERR   = 4;
  localparam int SEL_LOL   = 5;
  localparam int SEL_LED   = 6;
  localparam int SEL_INV   = 7;

  logic              clock = 1'b0;
  logic              i_reset;
  logic              i_enb_rx;
  logic              i_valid;
  logic              i_ref;
  logic              i_rx;
  logic              i_clr;
  logic [1:0]        o_state;
  logic              o_locked;
  logic [NB_DLY-1:0] o_delay;
  logic [NB_CNT-1:0] o_count_bit;
  logic [NB_CNT-1:0] o_count_err;
  logic [NB_LOL-1:0] o_lol_cnt;
  logic              o_led;
`ifdef BER_PHASE_AMBIG_EN
  logic              o_inverted;
`endif

  always #5 clock = ~clock;

  ber_sync_checker dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enb_rx    (i_enb_rx),
    .i_valid     (i_valid),
    .i_ref       (i_ref),
    .i_rx        (i_rx),
    .i_clr       (i_clr),
    .o_state     (o_state),
    .o_locked    (o_locked),
    .o_delay     (o_delay),
    .o_count_bit (o_count_bit),
    .o_count_err (o_count_err),
    .o_lol_cnt   (o_lol_cnt),
    .o_led       (o_led)
`ifdef BER_PHASE_AMBIG_EN
    ,
    .o_inverted  (o_inverted)
`endif
  );

  int          n_cmp   = 0;
  int          n_err   = 0;
  int          lock_n  = 0;
  bit          in_lock = 1'b0;
  logic [8:0]  lfsr    = 9'h1FF;
  logic [63:0] hist    = '0;

  string       tag_q[$];
  int          sel_q[$];
  logic [63:0] exp_q[$];

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end else begin
      $display("  ok   %s = %0d", tag, obs);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    logic [63:0] v;
    v = '0;
    case (sel)
      SEL_STATE: v = 64'(o_state);
      SEL_LOCK:  v = 64'(o_locked);
      SEL_DLY:   v = 64'(o_delay);
      SEL_BIT:   v = o_count_bit;
      SEL_ERR:   v = o_count_err;
      SEL_LOL:   v = 64'(o_lol_cnt);
      SEL_LED:   v = 64'(o_led);
`ifdef BER_PHASE_AMBIG_EN
      SEL_INV:   v = 64'(o_inverted);
`endif
      default:   v = '1;
    endcase
    return v;
  endfunction

  task automatic sb_push(input string tag, input int sel, input logic [63:0] exp);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
  endtask

  task automatic sb_drain();
    string       t;
    int          s;
    logic [63:0] e;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      chk_val(t, observe(s), e);
    end
  endtask

  // One valid sample. The task is entered and left on a falling edge.
  // e flips a single bit, inv inverts the received bit, and clr asserts
  // i_clr together with the sample.
  task automatic send(input bit e, input bit inv, input bit clr, input int gap);
    logic fb;
    logic rx;
    fb   = lfsr[8] ^ lfsr[4];
    lfsr = {lfsr[7:0], fb};
    rx   = hist[36];
    hist = {hist[62:0], fb};
    i_ref   = fb;
    i_rx    = rx ^ e ^ inv;
    i_valid = 1'b1;
    i_clr   = clr;
    @(negedge clock);
    i_valid = 1'b0;
    i_clr   = 1'b0;
    if (in_lock) lock_n++;
    repeat (gap) @(negedge clock);
  endtask

  initial begin
    int n_al;
    i_reset  = 1'b1;
    i_enb_rx = 1'b0;
    i_valid  = 1'b0;
    i_ref    = 1'b0;
    i_rx     = 1'b0;
    i_clr    = 1'b0;
    #1 i_reset = 1'b0;
    repeat (3) @(negedge clock);

    // Reset state
    sb_push("rst_state", SEL_STATE, 0);
    sb_push("rst_locked", SEL_LOCK, 0);
    sb_push("rst_delay", SEL_DLY, 0);
    sb_push("rst_bits", SEL_BIT, 0);
    sb_push("rst_errs", SEL_ERR, 0);
    sb_push("rst_lol", SEL_LOL, 0);
    sb_push("rst_led", SEL_LED, 0);
    sb_drain();

    i_reset = 1'b1;
    @(negedge clock);
    i_enb_rx = 1'b1;
    repeat (2) @(negedge clock);

    // Acquisition of a 37-sample delay: 38 search windows
    repeat (38 * SL - 1) send(0, 0, 0, 0);
    sb_push("acq_pre_state", SEL_STATE, 1);
    sb_push("acq_pre_locked", SEL_LOCK, 0);
    sb_push("acq_pre_delay", SEL_DLY, 37);
    sb_drain();
    send(0, 0, 0, 0);
    in_lock = 1'b1;
    sb_push("acq_state", SEL_STATE, 2);
    sb_push("acq_locked", SEL_LOCK, 1);
    sb_push("acq_delay", SEL_DLY, 37);
    sb_push("acq_bits", SEL_BIT, 0);
    sb_drain();

    // Clean run while locked
    repeat (10000) send(0, 0, 0, 0);
    sb_push("clean_bits", SEL_BIT, 10000);
    sb_push("clean_errs", SEL_ERR, 0);
    sb_push("clean_locked", SEL_LOCK, 1);
    sb_push("clean_led", SEL_LED, 1);
    sb_drain();

    // Clear on an idle cycle
    i_clr = 1'b1;
    @(negedge clock);
    i_clr = 1'b0;
    sb_push("clr_bits", SEL_BIT, 0);
    sb_push("clr_errs", SEL_ERR, 0);
    sb_drain();

    // 10 single-bit errors in 1000 bits, with 1-of-4 strobes
    for (int i = 0; i < 1000; i++) send((i % 100) == 50, 0, 0, 3);
    sb_push("err10_errs", SEL_ERR, 10);
    sb_push("err10_bits", SEL_BIT, 1000);
    sb_push("err10_locked", SEL_LOCK, 1);
    sb_push("err10_lol", SEL_LOL, 0);
    sb_push("err10_led", SEL_LED, 0);
    sb_drain();

    // Clear on the same cycle as an error; counting resumes afterwards
    send(1, 0, 1, 3);
    sb_push("clrhit_errs", SEL_ERR, 0);
    sb_push("clrhit_bits", SEL_BIT, 0);
    sb_drain();
    send(0, 0, 0, 3);
    sb_push("clrnext_bits", SEL_BIT, 1);
    sb_push("clrnext_errs", SEL_ERR, 0);
    sb_drain();

    // Align to a loss-of-lock window boundary, then invert a whole window
    n_al = 0;
    while ((lock_n % LW) != 0) begin
      send(0, 0, 0, 0);
      n_al++;
    end
    repeat (LW - 1) send(0, 1, 0, 0);
    sb_push("inv_pre_locked", SEL_LOCK, 1);
    sb_drain();
    send(0, 1, 0, 0);
    in_lock = 1'b0;
    sb_push("lol_state", SEL_STATE, 1);
    sb_push("lol_locked", SEL_LOCK, 0);
    sb_push("lol_cnt", SEL_LOL, 1);
    sb_push("lol_delay", SEL_DLY, 37);
    sb_push("lol_errs", SEL_ERR, LW);
    sb_push("lol_bits", SEL_BIT, 64'(1 + n_al + LW));
    sb_drain();

    // Reacquire at the same delay
`ifdef BER_PHASE_AMBIG_EN
    repeat (SL) send(0, 1, 0, 0);
    sb_push("relock_inv", SEL_INV, 1);
`else
    repeat (SL) send(0, 0, 0, 0);
`endif
    sb_push("relock_locked", SEL_LOCK, 1);
    sb_push("relock_state", SEL_STATE, 2);
    sb_push("relock_delay", SEL_DLY, 37);
    sb_drain();

    // Reset asserted mid-LOCK takes effect at once
    i_reset = 1'b0;
    #1;
    sb_push("arst_state", SEL_STATE, 0);
    sb_push("arst_locked", SEL_LOCK, 0);
    sb_push("arst_delay", SEL_DLY, 0);
    sb_push("arst_bits", SEL_BIT, 0);
    sb_push("arst_errs", SEL_ERR, 0);
    sb_push("arst_lol", SEL_LOL, 0);
    sb_drain();
    @(negedge clock);
    i_reset = 1'b1;
    repeat (2) @(negedge clock);

    // Disable during SEARCH at d=5, then resume
    repeat (5 * SL + 100) send(0, 0, 0, 0);
    sb_push("srch5_state", SEL_STATE, 1);
    sb_push("srch5_delay", SEL_DLY, 5);
    sb_drain();
    i_enb_rx = 1'b0;
    @(negedge clock);
    sb_push("dis_state", SEL_STATE, 0);
    sb_push("dis_delay", SEL_DLY, 5);
    sb_drain();
    i_enb_rx = 1'b1;
    @(negedge clock);
    sb_push("ren_state", SEL_STATE, 1);
    sb_push("ren_delay", SEL_DLY, 5);
    sb_drain();
    repeat (SL) send(0, 0, 0, 0);
    sb_push("ren_next_delay", SEL_DLY, 6);
    sb_push("ren_next_state", SEL_STATE, 1);
    sb_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ber_sync_checker.md
Name: ber_sync_checker

Overview:
- Parametrised next-generation BER checker for the I/Q PRBS9 links (TX PRBS9 -> polyphase filter -> downsampler -> checker).
- Replaces a fixed-delay compare with automatic delay acquisition: serial search over a reference delay line, a lock/loss-of-lock FSM, and saturating bit, error and LOL counters.
- One instance per channel; runs on the T/4 clock; the 1-of-4 qualifier `i_valid` gates all sample processing.

Parameters:
- NB_DLY, 10: delay-index width; delay line depth 2**NB_DLY; searchable delays 0 .. 2**NB_DLY-1.
- NB_CNT, 64: width of o_count_bit and o_count_err.
- SEARCH_LEN, 511: valid samples evaluated per candidate delay.
- ACQ_THR, 0: max errors in a search window for the candidate to be accepted.
- LOL_WIN, 512: valid samples per loss-of-lock window in LOCK.
- LOL_THR, 64: window errors above this value declare loss of lock.
- NB_LOL, 8: width of o_lol_cnt.

Ports:
- clock, in, 1: system clock (T/4).
- i_reset, in, 1: asynchronous reset, active-low.
- i_enb_rx, in, 1: receiver enable.
- i_valid, in, 1: sample strobe, one cycle per symbol T.
- i_ref, in, 1: local PRBS reference bit.
- i_rx, in, 1: received hard decision (downsampler MSB).
- i_clr, in, 1: synchronous clear of the counters.
- o_state, out, 2: 00 IDLE, 01 SEARCH, 10 LOCK.
- o_locked, out, 1: high in LOCK.
- o_delay, out, NB_DLY: current or locked candidate delay.
- o_count_bit, out, NB_CNT: bits compared while locked.
- o_count_err, out, NB_CNT: errors while locked.
- o_lol_cnt, out, NB_LOL: number of loss-of-lock events.
- o_led, out, 1: o_locked AND zero errors in the last completed LOL window.

Behaviour:
- Reset (async, i_reset=0): state IDLE; all outputs 0; delay line, window counters and d cleared.
- Delay line: on each (i_valid & i_enb_rx), shift in i_ref. Compared reference = i_ref when d=0, else i_ref from d valid samples earlier. err = i_rx XOR ref.
- IDLE -> SEARCH on the first cycle with i_enb_rx=1. SEARCH and LOCK -> IDLE whenever i_enb_rx=0. Window counters are reset on exit; d is kept; counters hold.
- SEARCH:
  - Count samples and errors for the current d.
  - On the valid sample that completes SEARCH_LEN, evaluate errors including that sample.
  - If errors <= ACQ_THR: enter LOCK; o_locked rises the next cycle.
  - Otherwise: d <= d+1, wrapping 2**NB_DLY-1 -> 0; restart the window.
- LOCK:
  - Each valid sample increments o_count_bit and adds err to o_count_err.
  - A LOL window counts samples and errors. At window end, if errors > LOL_THR: go to SEARCH starting at the same d, o_lol_cnt += 1, o_locked falls the next cycle. Otherwise restart the window and update the o_led flag.
- Saturation:
  - o_count_bit and o_count_err saturate at all-ones. Once o_count_bit saturates, both freeze.
  - o_lol_cnt saturates.
  - The search error counter saturates above ACQ_THR.
- i_clr zeroes o_count_bit, o_count_err and o_lol_cnt; FSM unaffected. If i_clr coincides with an increment, the clear wins.
- All outputs are registered; o_delay = d at all times.

Optional Feature:
- Macro: BER_PHASE_AMBIG_EN.
- Defined:
  - The search also tests the inverted compare (err = ~(i_rx XOR ref)) at each d, counted in parallel.
  - Accepts whichever polarity meets ACQ_THR; non-inverted wins on a tie.
  - Adds output o_inverted (1 bit, reset 0) holding the accepted polarity. LOCK compares with that polarity.
  - Resolves QPSK 180° ambiguity.
- Undefined: non-inverted only; o_inverted port absent.

Test Plan:
- Reset asserted mid-LOCK -> same cycle: o_state=00, o_locked=0, all counters 0, o_delay=0.
- i_rx = i_ref delayed 37 valid samples, defaults -> o_locked=1 with o_delay=37 after 38*511 valid samples; o_count_err stays 0 over 10000 bits.
- Locked at d=37, 10 single-bit errors in 1000 bits -> o_count_err=10, o_count_bit=1000, o_locked stays 1, o_lol_cnt=0.
- Locked, then i_rx inverted for 512 bits -> at window end o_locked=0, o_state=01, o_lol_cnt=1, o_delay=37. With BER_PHASE_AMBIG_EN: relock at 37 with o_inverted=1 after 511 more bits.
- i_enb_rx=0 during SEARCH at d=5 -> o_state=00, o_delay=5. Re-enable -> search resumes at d=5.
- i_clr on the same cycle as an error in LOCK -> o_count_err=0, o_count_bit=0 the next cycle; counting resumes on the following valid sample.
